// File: rtl/rst_stretch.sv
// rst_stretch: reset/flag stretcher; asserts asynchronously on i_rst and
// releases synchronously to clk after a synchronizer plus TICK-cycle hold.
module rst_stretch #(
   parameter int unsigned TICK        = 100_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic i_rst,
   output logic o_rst
);
   localparam int unsigned W = (TICK == 0) ? 1 : $clog2(64'(TICK) + 64'd1);
   localparam logic [W-1:0] LOAD = W'(TICK);
   // Power-on values make o_rst come up asserted without any i_rst pulse.
   logic [SYNC_STAGES-1:0] sync = '1;
   logic [W-1:0] cnt = LOAD;
   logic o_q = 1'b1;
   logic rel_n;
   assign rel_n = sync[SYNC_STAGES-1];
   assign o_rst = o_q;
   // With no hold count, release on the edge where the synchronizer drains.
   always_ff @(posedge clk or posedge i_rst)
      if (i_rst) begin
         sync <= '1;
         cnt  <= LOAD;
         o_q  <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b0};
         cnt  <= rel_n ? LOAD : (cnt != '0 ? cnt - W'(1) : cnt);
         o_q  <= (TICK == 0) ? sync[SYNC_STAGES-2] : (rel_n || cnt > W'(1));
      end
endmodule

// File: tb/tb_rst_stretch.sv
// tb_rst_stretch: random and directed checks of three rst_stretch configurations
// against a model that counts clk edges since the last i_rst release.
`timescale 1ns/1ps
module tb_rst_stretch;
   logic clk = 1'b0;
   logic i_rst = 1'b0;
   logic o4, o0, o300;
   int n_assert = 0;
   int n_fail = 0;
   int k = 0;

   localparam int HOLD4 = 2 + 4;
   localparam int HOLD0 = 2;
   localparam int HOLD300 = 3 + 300;

   rst_stretch #(.TICK(4), .SYNC_STAGES(2)) u4 (.clk(clk), .i_rst(i_rst), .o_rst(o4));
   rst_stretch #(.TICK(0), .SYNC_STAGES(2)) u0 (.clk(clk), .i_rst(i_rst), .o_rst(o0));
   rst_stretch #(.TICK(300), .SYNC_STAGES(3)) u300 (.clk(clk), .i_rst(i_rst), .o_rst(o300));

   always #5 clk = ~clk;

   // Reference: edges seen with i_rst low since it was last high.
   always @(posedge i_rst) k = 0;
   always @(posedge clk) if (!i_rst && k < 1_000_000) k = k + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (k=%0d t=%0t)", tag, obs, exp, k, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_t4"}, 32'(o4), 32'(i_rst || k < HOLD4));
      check({tag, "_t0"}, 32'(o0), 32'(i_rst || k < HOLD0));
      check({tag, "_t300"}, 32'(o300), 32'(i_rst || k < HOLD300));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_all("cycle");
      end
   endtask

   // Called at a negedge; raises i_rst mid-cycle and drops it mid-cycle later.
   task automatic pulse(input int cycles);
      #2 i_rst = 1'b1;
      #0.5 check_all("async_set");
      if (cycles == 0) begin
         #0.5 i_rst = 1'b0;
         @(negedge clk);
         check_all("glitch");
      end else begin
         run(cycles);
         #2 i_rst = 1'b0;
         @(negedge clk);
         check_all("release");
      end
   endtask

   initial begin
      #1 check_all("powerup");
      run(310);
      pulse(2);
      run(310);
      pulse(0);
      run(10);
      pulse(2);
      run(3);
      check("cnt_mid", 32'(u4.cnt), 32'd2);
      pulse(3);
      run(10);
      #2 i_rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check_all("held");
         check("cnt_held", 32'(u4.cnt), 32'd4);
      end
      #2 i_rst = 1'b0;
      run(310);
      for (int i = 0; i < 40; i++) begin
         pulse($urandom_range(0, 3));
         run($urandom_range(0, 9));
      end
      run(310);
      check("idle_cnt", 32'(u4.cnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
